// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Single-port memory arbiter/responder for the pipelined datapath. Serialises
//   instruction-fetch and data-access requests onto one RAM port and answers
//   each with a one-cycle ihit/dhit pulse plus registered load data. Data
//   requests win over fetches; ihit and dhit are never high together.
//
//   Parameters
//     TIMEOUT  max consecutive non-ACCESS cycles a RAM transaction may take
//     CNT_W    wait counter width, must satisfy 2**CNT_W > TIMEOUT
//
//   Ports
//     CLK, nRST                 clock, asynchronous active-low reset
//     iREN, iaddr               fetch request (held until ihit) and address
//     ihit, iload               fetch completion pulse, fetched word (held)
//     dREN, dWEN, daddr, dstore data request (write wins if both), addr, data
//     dhit, dload               data completion pulse, read data (held)
//     ramREN, ramWEN            RAM strobes
//     ramaddr, ramstore         RAM address / write data
//     ramload, ramstate         RAM read data / status (FREE,BUSY,ACCESS,ERROR)
//     fault                     sticky error flag, cleared only by reset
//
//   All outputs are registered; there is no combinational input-to-output path.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        fault
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    INSTR,
    RESP,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state;
  logic             wr;     // latched write flag of the current data access
  logic [CNT_W-1:0] cnt;    // consecutive non-ACCESS cycles of this access
  ramstate_t        rs;

  always_comb begin
    rs = ramstate_t'(ramstate);
  end

  // ramaddr/ramstore double as the latched request address/data: they are
  // loaded when leaving IDLE and held for the whole transaction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      wr       <= 1'b0;
      cnt      <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      fault    <= 1'b0;
    end else begin
      // hits are single-cycle pulses raised only on the way into RESP
      ihit <= 1'b0;
      dhit <= 1'b0;

      case (state)
        IDLE: begin
          if (dREN || dWEN) begin
            ramaddr  <= daddr;
            ramstore <= dstore;
            wr       <= dWEN;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
            cnt      <= '0;
            state    <= DATA;
          end else if (iREN) begin
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            cnt     <= '0;
            state   <= INSTR;
          end
        end

        DATA, INSTR: begin
          if (rs == ERROR) begin
            fault  <= 1'b1;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= FAULT;
          end else if (rs == ACCESS) begin
            if (state == DATA) begin
              dhit <= 1'b1;
              if (!wr) begin
                dload <= ramload;
              end
            end else begin
              ihit  <= 1'b1;
              iload <= ramload;
            end
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= RESP;
          end else if (cnt == TMO) begin
            // TIMEOUT non-ACCESS cycles already elapsed and this is another
            fault  <= 1'b1;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= FAULT;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          // always back to IDLE so a still-high request is not re-serviced here
          state <= IDLE;
        end

        FAULT: begin
          state <= FAULT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
